// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam int          DEPTH_DEF   = 64;
   localparam logic [31:0] HALT_OPCODE = 32'h0000_007F;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the RUN state: hlt > jump > stall > increment.
module pc_next_sel
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic [31:0] pc,
   input  logic        hlt,
   input  logic        jump,
   input  logic        stall,
   input  logic [31:0] tgt,
   output logic [31:0] pc_nxt,
   output state_e      st_nxt,
   output logic        err_set,
   output logic        adv
);

   always_comb begin
      pc_nxt  = pc;
      st_nxt  = RUN;
      err_set = 1'b0;
      adv     = 1'b0;
      if (hlt) begin
         st_nxt = HALT;
      end else if (jump) begin
         if (tgt < 32'(DEPTH)) begin
            pc_nxt = tgt;
            adv    = 1'b1;
         end else begin
            err_set = 1'b1;
            st_nxt  = HALT;
         end
      end else if (!stall) begin
         // Running off the end of memory halts rather than wrapping to 0.
         if (pc == 32'(DEPTH - 1)) begin
            st_nxt = HALT;
         end else begin
            pc_nxt = pc + 32'd1;
            adv    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: loads a program into instruction memory, then sequences the PC.
// Optional macro FETCH_CNT_EN adds a saturating fetch_cnt output.
module fetch_controller
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_valid,
   output logic          ld_ready,
   input  logic [31:0]   ld_data,
   input  logic          ld_last,
   input  logic          restart,
   input  logic          hlt,
   input  logic          stall,
   input  logic          jump,
   input  logic [31:0]   next,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          fetch_valid,
   output logic [31:0]   PC,
   output logic [31:0]   nextPC,
   output logic [1:0]    state,
   output logic          err
`ifdef FETCH_CNT_EN
   ,
   output logic [31:0]   fetch_cnt
`endif
);

   state_e        st_q;
   logic [AW-1:0] ptr;
   logic [31:0]   pc_q;
   logic [31:0]   npc_q;
   logic          err_q;
   logic          fv_q;

   logic [31:0]   sel_pc;
   state_e        sel_st;
   logic          sel_err;
   logic          sel_adv;

   pc_next_sel #(.DEPTH(DEPTH)) u_sel (
      .pc      (pc_q),
      .hlt     (hlt),
      .jump    (jump),
      .stall   (stall),
      .tgt     (next),
      .pc_nxt  (sel_pc),
      .st_nxt  (sel_st),
      .err_set (sel_err),
      .adv     (sel_adv)
   );

   // Gating with rst_n keeps the loader handshake and write strobe dead while reset is held.
   assign ld_ready    = rst_n && (st_q == LOAD);
   assign mem_we      = ld_valid && ld_ready;
   assign mem_addr    = (st_q == LOAD) ? ptr : pc_q[AW-1:0];
   assign mem_wdata   = ld_data;
   assign fetch_valid = fv_q;
   assign PC          = pc_q;
   assign nextPC      = npc_q;
   assign state       = st_q;
   assign err         = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= LOAD;
         ptr   <= '0;
         pc_q  <= 32'd0;
         npc_q <= 32'd1;
         err_q <= 1'b0;
         fv_q  <= 1'b0;
      end else begin
         case (st_q)
            LOAD: begin
               if (mem_we) begin
                  // A full memory without ld_last is an overflow: flag it and run what we have.
                  if (ld_last || (ptr == AW'(DEPTH - 1))) begin
                     st_q  <= RUN;
                     fv_q  <= 1'b1;
                     pc_q  <= 32'd0;
                     npc_q <= 32'd1;
                     if (!ld_last) err_q <= 1'b1;
                  end
                  if (ptr != AW'(DEPTH - 1)) ptr <= ptr + AW'(1);
               end
            end
            RUN: begin
               st_q  <= sel_st;
               pc_q  <= sel_pc;
               npc_q <= sel_pc + 32'd1;
               fv_q  <= (sel_st == RUN);
               if (sel_err) err_q <= 1'b1;
            end
            HALT: begin
               if (restart) begin
                  st_q  <= LOAD;
                  ptr   <= '0;
                  err_q <= 1'b0;
               end
            end
            default: begin
               st_q <= LOAD;
               fv_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= 32'd0;
      end else if (st_q == HALT && restart) begin
         fetch_cnt <= 32'd0;
      end else if (st_q == RUN && sel_adv && fetch_cnt != 32'hFFFF_FFFF) begin
         fetch_cnt <= fetch_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_controller;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          ld_valid, ld_last, restart, hlt, stall, jump;
   logic [31:0]   ld_data, next;
   logic          ld_ready, mem_we, fetch_valid, err;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, PC, nextPC;
   logic [1:0]    state;
`ifdef FETCH_CNT_EN
   logic [31:0]   fetch_cnt;
`endif

   fetch_controller #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .restart     (restart),
      .hlt         (hlt),
      .stall       (stall),
      .jump        (jump),
      .next        (next),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .fetch_valid (fetch_valid),
      .PC          (PC),
      .nextPC      (nextPC),
      .state       (state),
      .err         (err)
`ifdef FETCH_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;

   // Reference model: 0=LOAD 1=RUN 2=HALT, load pointer, PC, sticky error, fetch count.
   int          m_state;
   int          m_ptr;
   logic [31:0] m_pc;
   logic        m_err;
   logic [31:0] m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_ptr   = 0;
      m_pc    = 32'd0;
      m_err   = 1'b0;
      m_cnt   = 32'd0;
   endtask

   task automatic model_step();
      case (m_state)
         0: if (ld_valid) begin
               if (ld_last || m_ptr == DEPTH - 1) begin
                  if (!ld_last) m_err = 1'b1;
                  m_state = 1;
                  m_pc    = 32'd0;
               end
               if (m_ptr < DEPTH - 1) m_ptr++;
            end
         1: if (hlt) m_state = 2;
            else if (jump) begin
               if (next < DEPTH) begin
                  m_pc = next;
                  if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
               end else begin
                  m_err   = 1'b1;
                  m_state = 2;
               end
            end else if (!stall) begin
               if (m_pc == DEPTH - 1) m_state = 2;
               else begin
                  m_pc++;
                  if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
               end
            end
         default: if (restart) begin
               m_state = 0;
               m_ptr   = 0;
               m_err   = 1'b0;
               m_cnt   = 32'd0;
            end
      endcase
   endtask

   task automatic check_regs();
      check("state", state, m_state);
      check("pc", PC, m_pc);
      check("nextpc", nextPC, m_pc + 32'd1);
      check("err", err, m_err);
      check("fetch_valid", fetch_valid, m_state == 1);
`ifdef FETCH_CNT_EN
      check("fetch_cnt", fetch_cnt, m_cnt);
`endif
   endtask

   // Inputs are already driven; check combinational outputs, advance one clock, check registers.
   task automatic cycle();
      #1;
      check("ld_ready", ld_ready, m_state == 0);
      check("mem_we", mem_we, (m_state == 0) && ld_valid);
      check("mem_addr", mem_addr, (m_state == 0) ? m_ptr : int'(m_pc[AW-1:0]));
      if (mem_we) check("mem_wdata", mem_wdata, ld_data);
      model_step();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic idle_inputs();
      ld_valid = 1'b0; ld_last = 1'b0; ld_data = 32'd0; restart = 1'b0;
      hlt = 1'b0; stall = 1'b0; jump = 1'b0; next = 32'd0;
   endtask

   task automatic load_seq(input int n, input bit last_end, input string tag);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = $urandom;
         ld_last  = last_end && (i == n - 1);
         #1;
         check(tag, mem_addr, i);
         cycle();
      end
      idle_inputs();
   endtask

   task automatic reset_check(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_pc"}, PC, 0);
      check({tag, "_npc"}, nextPC, 1);
      check({tag, "_err"}, err, 0);
      check({tag, "_fv"}, fetch_valid, 0);
      check({tag, "_ready"}, ld_ready, 0);
      check({tag, "_we"}, mem_we, 0);
   endtask

   task automatic pulse_reset(input string tag);
      ld_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1 reset_check(tag);
      model_reset();
      @(posedge clk);
      #1 reset_check(tag);
      #2 rst_n = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      model_reset();
      pulse_reset("rst");

      // Three-word program, then four free-running cycles.
      load_seq(3, 1'b1, "ld3_addr");
      check("ld3_state", state, 1);
      check("ld3_pc", PC, 0);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         check("free_pc", PC, i);
         check("free_npc", nextPC, i + 1);
      end

      // Jump wins over stall.
      jump = 1'b1; stall = 1'b1; next = 32'd12;
      cycle();
      check("jmp_pc", PC, 12);
      check("jmp_npc", nextPC, 13);
      idle_inputs();

      // Halt wins over jump; then restart.
      jump = 1'b1; next = 32'd7;
      cycle();
      hlt = 1'b1; next = 32'd5;
      cycle();
      check("hlt_state", state, 2);
      check("hlt_pc", PC, 7);
      check("hlt_fv", fetch_valid, 0);
      idle_inputs();
      restart = 1'b1;
      cycle();
      check("rst_state", state, 0);
      idle_inputs();

      // Out-of-range jump.
      load_seq(1, 1'b1, "ld1_addr");
      jump = 1'b1; next = 32'd64;
      cycle();
      check("oor_err", err, 1);
      check("oor_state", state, 2);
      idle_inputs();
      restart = 1'b1;
      cycle();
      check("oor_clr", err, 0);
      idle_inputs();

      // Load overflow: 64 words without ld_last.
      load_seq(DEPTH, 1'b0, "ovf_addr");
      check("ovf_err", err, 1);
      check("ovf_state", state, 1);
      check("ovf_pc", PC, 0);
      hlt = 1'b1;
      cycle();
      idle_inputs();
      restart = 1'b1;
      cycle();
      idle_inputs();

      // Reset in the middle of a load restarts writing at address 0.
      load_seq(10, 1'b0, "mid_addr");
      pulse_reset("midrst");
      load_seq(3, 1'b1, "reld_addr");

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         ld_valid = ($urandom_range(0, 3) != 0);
         ld_last  = ($urandom_range(0, 15) == 0);
         ld_data  = $urandom;
         restart  = ($urandom_range(0, 3) == 0);
         hlt      = ($urandom_range(0, 40) == 0);
         jump     = ($urandom_range(0, 9) == 0);
         stall    = ($urandom_range(0, 4) == 0);
         next     = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 70);
         cycle();
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 64, instruction-memory depth in words.
REQ-002 SHALL have parameter AW, default 6, memory address width (clog2 DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ld_valid  in  1  loader word valid.
REQ-006 ld_ready  out  1  controller accepts loader word.
REQ-007 ld_data  in  32  instruction word to store.
REQ-008 ld_last  in  1  final word of program.
REQ-009 restart  in  1  HALT-to-LOAD request.
REQ-010 hlt  in  1  core halt request.
REQ-011 stall  in  1  hold PC for one cycle.
REQ-012 jump  in  1  redirect to next.
REQ-013 next  in  32  absolute word-address jump target.
REQ-014 mem_we  out  1  instruction-memory write enable.
REQ-015 mem_addr  out  AW  instruction-memory address.
REQ-016 mem_wdata  out  32  instruction-memory write data.
REQ-017 fetch_valid  out  1  mem read data at PC is a valid instruction.
REQ-018 PC  out  32  current word address.
REQ-019 nextPC  out  32  PC+1, link value for jal/jalr.
REQ-020 state  out  2  LOAD=0, RUN=1, HALT=2.
REQ-021 err  out  1  sticky: load overflow or out-of-range jump.

Function
REQ-022 LOAD: ld_ready=1, fetch_valid=0. Each ld_valid&ld_ready cycle drives mem_we=1, mem_addr=ptr, mem_wdata=ld_data, then increments ptr. ld_ready and mem_we are combinational in LOAD.
REQ-023 LOAD->RUN on the cycle after a word with ld_last is accepted; PC=0, nextPC=1.
REQ-024 A word accepted at ptr=DEPTH-1 without ld_last SHALL set err and force LOAD->RUN. ptr never wraps.
REQ-025 RUN: fetch_valid=1, mem_we=0, mem_addr=PC[AW-1:0]. Next-PC priority per cycle: hlt > jump > stall > increment.
REQ-026 hlt: next state HALT; PC and nextPC held. Simultaneous jump is ignored.
REQ-027 jump with next<DEPTH: PC<=next, nextPC<=next+1.
REQ-028 jump with next>=DEPTH: set err, go to HALT, PC held.
REQ-029 stall only: PC and nextPC held.
REQ-030 Otherwise: PC<=PC+1, nextPC<=PC+2. If PC=DEPTH-1, go to HALT instead of wrapping.
REQ-031 HALT: fetch_valid=0, ld_ready=0, PC held. restart goes to LOAD with ptr=0 and err cleared. All other inputs are ignored.
REQ-032 Outputs SHALL be registered except ld_ready, mem_we, mem_addr and mem_wdata.

Reset
REQ-033 rst_n low SHALL immediately set state=LOAD, ptr=0, PC=0, nextPC=1, err=0, fetch_valid=0, mem_we=0, ld_ready=0 while asserted. This applies even mid-load or mid-run.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-035 Macro FETCH_CNT_EN defined: add output fetch_cnt (32), cleared on reset and on restart. It increments on each RUN cycle where PC advances or jumps, and saturates at all-ones.
REQ-036 FETCH_CNT_EN undefined: no fetch_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum (LOAD/RUN/HALT), the default DEPTH and the HALT opcode constant 32'h0000007F.
REQ-038 Sub-module pc_next_sel SHALL hold the combinational priority mux (REQ-025..030), returning next PC, next state and the err-set pulse.

Verification
REQ-039 Load 3 words, ld_last on the 3rd -> mem_we pulses at addr 0,1,2; RUN next cycle with PC=0.
REQ-040 RUN 4 free cycles -> PC sequence 0,1,2,3,4; nextPC is always PC+1.
REQ-041 jump=1, next=12, with stall=1 the same cycle -> PC=12, nextPC=13.
REQ-042 hlt=1 and jump=1, next=5, at PC=7 -> HALT, PC=7, fetch_valid=0; restart -> LOAD.
REQ-043 jump next=64 -> err=1, HALT. Separately, load 64 words with no ld_last -> err=1, RUN at PC=0.
REQ-044 rst_n low mid-load after 10 words -> LOAD, ptr=0; reload writes from addr 0.
